mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store initiator for the word-wide synchronous RAM (ram / ram_dp data port).
//  Accepts one CPU data request at a time over a valid/ready handshake and drives the RAM
//  address, data and write-enable lines. Byte and halfword stores use read-modify-write,
//  because the RAM has no byte enables. Returns load data with sign/zero extension.
//  Sits between the core's MEM stage and the RAM data port.
// PARAMETERS
//  DEPTH     1024  RAM depth in 32-bit words; RAM address width = $clog2(DEPTH)
//  RD_LAT    1     RAM read latency in cycles, from mem_addr valid to mem_rdata valid (>=1)
//  BASE_ADDR 0     Byte address mapped to RAM word 0
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid && req_ready
//  req_we     in   1   1 = store, 0 = load
//  req_size   in   2   0 = byte, 1 = half, 2 = word; 3 = illegal (error)
//  req_signed in   1   load sign-extend (1) or zero-extend (0)
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-aligned
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   response consumed when rsp_valid && rsp_ready
//  rsp_rdata  out  32  load result (0 for stores and errors)
//  rsp_err    out  1   misaligned, out of range, or size==3
//  mem_addr   out  $clog2(DEPTH)  RAM word address
//  mem_wdata  out  32  to RAM data_i
//  mem_we     out  1   RAM write_en
//  mem_rdata  in   32  from RAM data_o
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0,
//    mem_addr=0, mem_wdata=0.
//  - FSM: IDLE -> READ (RD_LAT cycles) -> CAP (1 cycle) -> RESP -> IDLE; IDLE -> RESP on error.
//  - req_ready=1 only in IDLE. Accept in cycle T latches all req_* fields.
//  - word = (req_addr-BASE_ADDR)>>2; lane = addr[1:0]. Error if half && lane[0],
//    word && lane!=0, size==3, addr<BASE_ADDR, or word>=DEPTH. On error: no RAM access;
//    rsp_valid=1 with rsp_err=1 from T+1.
//  - mem_addr = latched word index, held from T+1 until leaving CAP.
//  - CAP cycle T+1+RD_LAT:
//    - load: extract lane bytes (little-endian), extend per req_signed, register into rsp_rdata.
//    - store: mem_wdata = mem_rdata with the addressed lane(s) replaced by req_wdata[7:0]/[15:0]/[31:0];
//      mem_we=1 for exactly this cycle.
//  - RESP from T+2+RD_LAT: rsp_valid, rsp_rdata and rsp_err are held stable until
//    rsp_ready. Back to IDLE on the handshake edge; the next accept is possible in the
//    following cycle.
//  - mem_we is never high outside CAP; only one write per store.
//  - Reset mid-transaction: returns to IDLE at the next edge. A write already driven in
//    that cycle completes. No response is issued for the aborted request.
// CONFIGURATION
//  MEMCTL_FAST_WORD_STORE_EN defined:
//    - Aligned in-range word stores skip READ. mem_we=1 with mem_wdata=req_wdata at T+1
//      (state CAP).
//    - rsp_valid from T+2.
//    - Byte/half stores and all loads are unchanged.
//  Not defined:
//    - All stores use read-modify-write timing: mem_we at T+1+RD_LAT.
// TESTING
//  1 RAM[5]=0x8899AABB; load byte addr 0x16 signed -> rsp_rdata=0xFFFFFF99 at T+3
//    (RD_LAT=1), rsp_err=0, mem_we never 1.
//  2 RAM[5]=0x8899AABB; store half 0x1234 to 0x14 -> single mem_we at T+2 with
//    mem_wdata=0x88991234; later word load of 0x14 returns 0x88991234.
//  3 Word load of 0x13 -> rsp_err=1 at T+1, rsp_rdata=0, mem_we=0, no READ state.
//  4 Load of 0x1000 with DEPTH=1024 -> rsp_err=1; size==3 -> rsp_err=1.
//  5 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0. Release -> req_ready=1
//    next cycle, back-to-back requests accepted.
//  6 Store byte to 0x8, reset asserted at T+1 -> IDLE, no mem_we, no rsp_valid.
//    With MEMCTL_FAST_WORD_STORE_EN, word store of 0xDEADBEEF -> mem_we at T+1, rsp at T+2.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus RAM data-port bus for mem_access_ctrl.
// slave = controller view, master = CPU/RAM side (testbench) view.
interface mem_access_ctrl_if #(
  parameter int AW = 10
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-wide synchronous RAM; sub-word stores use read-modify-write.
// Optional feature macro: MEMCTL_FAST_WORD_STORE_EN (aligned word stores skip the RAM read).
module mem_access_ctrl #(
  parameter int          DEPTH     = 1024,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic clock,
  input  logic reset,
  mem_access_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, READ, CAP, RESP} state_t;

  state_t        state;
  logic          we_q;
  logic          signed_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt;

  logic [31:0]   off;
  logic [31:0]   word_idx;
  logic          req_err;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    case (size)
      2'd0:    return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      2'd1:    return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] mask;
    case (size)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {lane, 3'b000};
    return (old & ~mask) | ((wd << {lane, 3'b000}) & mask);
  endfunction

  always_comb begin
    off      = bus.req_addr - BASE_ADDR;
    word_idx = off >> 2;
    req_err  = (bus.req_size == 2'd3) ||
               (bus.req_size == 2'd1 && bus.req_addr[0]) ||
               (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0) ||
               (bus.req_addr < BASE_ADDR) ||
               (word_idx >= 32'(DEPTH));
  end

  // RAM read data is only valid during CAP, so the merged write word is formed combinationally.
  // A word store has an all-ones mask, so the same merge also covers the fast path.
  assign bus.mem_wdata = (state == CAP && we_q) ? store_merge(bus.mem_rdata, wdata_q, lane_q, size_q)
                                                : 32'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            we_q          <= bus.req_we;
            signed_q      <= bus.req_signed;
            size_q        <= bus.req_size;
            lane_q        <= bus.req_addr[1:0];
            wdata_q       <= bus.req_wdata;
            if (req_err) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= 32'h0;
              state         <= RESP;
            end else begin
              bus.mem_addr <= word_idx[AW-1:0];
`ifdef MEMCTL_FAST_WORD_STORE_EN
              if (bus.req_we && bus.req_size == 2'd2) begin
                bus.mem_we <= 1'b1;
                state      <= CAP;
              end else begin
                cnt   <= CW'(RD_LAT - 1);
                state <= READ;
              end
`else
              cnt   <= CW'(RD_LAT - 1);
              state <= READ;
`endif
            end
          end
        end
        READ: begin
          if (cnt == '0) begin
            bus.mem_we <= we_q;
            state      <= CAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        CAP: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= we_q ? 32'h0 : load_extend(bus.mem_rdata, lane_q, size_q, signed_q);
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (DEPTH=1024, RD_LAT=1, BASE_ADDR=0) with a 1-cycle RAM model.
module tb_mem_access_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   we_count = 0;
  int   we_save;
  logic [31:0] ram [0:1023];

  mem_access_ctrl_if #(.AW(10)) bus ();

  mem_access_ctrl #(.DEPTH(1024), .RD_LAT(1), .BASE_ADDR(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      ram[5]    <= 32'h8899AABB;
      ram[8]    <= 32'h11223344;
      ram[12]   <= 32'h00000000;
      ram[1023] <= 32'hCAFEF00D;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_we) we_count <= we_count + 1;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  task automatic consume(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, "_ready_back"}, 32'(bus.req_ready), 32'h1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'h1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
    check("rst_mem_we",    32'(bus.mem_we),    32'h0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
    check("rst_mem_wdata", bus.mem_wdata,      32'h0);
    reset = 1'b0;
    tick();

    // signed byte load from lane 2 of word 5
    we_save = we_count;
    issue(1'b0, 2'd0, 1'b1, 32'h16, 32'h0);
    check("lb_busy",     32'(bus.req_ready), 32'h0);
    check("lb_mem_addr", 32'(bus.mem_addr),  32'h5);
    check("lb_t1_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    check("lb_t2_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    check("lb_valid", 32'(bus.rsp_valid), 32'h1);
    check("lb_rdata", bus.rsp_rdata,      32'hFFFFFF99);
    check("lb_err",   32'(bus.rsp_err),   32'h0);
    consume("lb");
    check("lb_no_write", 32'(we_count - we_save), 32'h0);

    // halfword store: read-modify-write into word 5
    we_save = we_count;
    issue(1'b1, 2'd1, 1'b0, 32'h14, 32'h00001234);
    check("sh_t1_we", 32'(bus.mem_we), 32'h0);
    tick();
    check("sh_we",       32'(bus.mem_we),   32'h1);
    check("sh_wdata",    bus.mem_wdata,     32'h88991234);
    check("sh_mem_addr", 32'(bus.mem_addr), 32'h5);
    tick();
    check("sh_we_off", 32'(bus.mem_we),    32'h0);
    check("sh_valid",  32'(bus.rsp_valid), 32'h1);
    check("sh_rdata",  bus.rsp_rdata,      32'h0);
    check("sh_err",    32'(bus.rsp_err),   32'h0);
    consume("sh");
    check("sh_one_write", 32'(we_count - we_save), 32'h1);

    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    tick();
    tick();
    check("lw_back", bus.rsp_rdata, 32'h88991234);
    consume("lw");

    issue(1'b0, 2'd1, 1'b1, 32'h16, 32'h0);
    tick();
    tick();
    check("lh_signed", bus.rsp_rdata, 32'hFFFF8899);
    consume("lh");

    // error cases: no RAM access, response the cycle after accept
    we_save = we_count;
    issue(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
    check("mis_valid", 32'(bus.rsp_valid), 32'h1);
    check("mis_err",   32'(bus.rsp_err),   32'h1);
    check("mis_rdata", bus.rsp_rdata,      32'h0);
    check("mis_we",    32'(bus.mem_we),    32'h0);
    consume("mis");
    issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    check("oor_err", 32'(bus.rsp_err), 32'h1);
    consume("oor");
    issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    check("sz3_err", 32'(bus.rsp_err), 32'h1);
    consume("sz3");
    issue(1'b1, 2'd1, 1'b0, 32'h15, 32'hFFFF);
    check("mish_err", 32'(bus.rsp_err), 32'h1);
    consume("mish");
    check("err_no_write", 32'(we_count - we_save), 32'h0);

    // last word in range is legal
    issue(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0);
    tick();
    tick();
    check("top_err",   32'(bus.rsp_err), 32'h0);
    check("top_rdata", bus.rsp_rdata,    32'hCAFEF00D);
    consume("top");

    // backpressure: response held while a new request waits
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    tick();
    tick();
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h21;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_rdata", bus.rsp_rdata,      32'h11223344);
      check("bp_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_idle_ready", 32'(bus.req_ready), 32'h1);
    check("bp_idle_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    bus.req_valid = 1'b0;
    check("b2b_busy", 32'(bus.req_ready), 32'h0);
    check("b2b_addr", 32'(bus.mem_addr),  32'h8);
    tick();
    tick();
    check("b2b_rdata", bus.rsp_rdata, 32'h00000033);
    consume("b2b");

    // byte store into lane 3
    issue(1'b1, 2'd0, 1'b0, 32'h23, 32'hFFFFFF5A);
    tick();
    check("sb_we",    32'(bus.mem_we), 32'h1);
    check("sb_wdata", bus.mem_wdata,   32'h5A223344);
    tick();
    consume("sb");

    // aligned word store timing
    we_save = we_count;
    issue(1'b1, 2'd2, 1'b0, 32'h30, 32'hDEADBEEF);
`ifdef MEMCTL_FAST_WORD_STORE_EN
    check("sw_we",    32'(bus.mem_we), 32'h1);
    check("sw_wdata", bus.mem_wdata,   32'hDEADBEEF);
    tick();
    check("sw_valid", 32'(bus.rsp_valid), 32'h1);
`else
    check("sw_t1_we", 32'(bus.mem_we), 32'h0);
    tick();
    check("sw_we",    32'(bus.mem_we), 32'h1);
    check("sw_wdata", bus.mem_wdata,   32'hDEADBEEF);
    tick();
    check("sw_valid", 32'(bus.rsp_valid), 32'h1);
`endif
    consume("sw");
    check("sw_one_write", 32'(we_count - we_save), 32'h1);
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    tick();
    tick();
    check("sw_back", bus.rsp_rdata, 32'hDEADBEEF);
    consume("swb");

    // reset in the cycle after accepting a byte store aborts it
    we_save = we_count;
    issue(1'b1, 2'd0, 1'b0, 32'h8, 32'hA5);
    reset = 1'b1;
    tick();
    check("abort_we",    32'(bus.mem_we),    32'h0);
    check("abort_valid", 32'(bus.rsp_valid), 32'h0);
    check("abort_ready", 32'(bus.req_ready), 32'h1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_quiet", 32'(bus.rsp_valid), 32'h0);
    end
    check("abort_no_write", 32'(we_count - we_save), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
